// File: rtl/secure_mem_pkg.sv
// Shared types and constants for the password-protected RAM/ROM controller.
package secure_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ACCESS,
    RESP,
    LOCKOUT
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BAD_PWD = 2'b01;
  localparam logic [1:0] ERR_ROM_WP  = 2'b10;

  localparam logic BANK_RAM = 1'b0;
  localparam logic BANK_ROM = 1'b1;

endpackage

// File: rtl/secure_mem_lockout.sv
// Consecutive password-failure counter and lockout duration timer.
// Only instantiated when SECURE_MEM_LOCKOUT_EN is defined.
module secure_mem_lockout #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_checkEn,
  input  logic i_pwdOk,
  input  logic i_lockStart,
  input  logic i_lockEnd,
  output logic o_lockReq,
  output logic o_timerDone
);

  localparam int CNT_W = (MAX_FAIL < 1) ? 1 : $clog2(MAX_FAIL + 1);
  localparam int TMR_W = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1);

  logic [CNT_W-1:0] r_failCount;
  logic [TMR_W-1:0] r_timer;

  // Timer is loaded with LOCK_CYCLES-1 so the lockout state lasts exactly LOCK_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_failCount <= '0;
      r_timer     <= '0;
    end else begin
      if (i_lockEnd) begin
        r_failCount <= '0;
      end else if (i_checkEn) begin
        if (i_pwdOk) begin
          r_failCount <= '0;
        end else if (r_failCount != CNT_W'(MAX_FAIL)) begin
          r_failCount <= r_failCount + 1'b1;
        end
      end

      if (i_lockStart) begin
        r_timer <= TMR_W'(LOCK_CYCLES - 1);
      end else if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign o_lockReq   = (r_failCount == CNT_W'(MAX_FAIL));
  assign o_timerDone = (r_timer == '0);

endmodule

// File: rtl/secure_mem_ctrl.sv
// Password-gated controller for a RAM bank and a write-once ROM bank.
// Define SECURE_MEM_LOCKOUT_EN to enable the failed-password lockout.
module secure_mem_ctrl
  import secure_mem_pkg::*;
#(
  parameter int               DATA_W      = 8,
  parameter int               ADDR_W      = 4,
  parameter int               PWD_W       = 8,
  parameter logic [PWD_W-1:0] RAM_PWD     = 8'hBF,
  parameter logic [PWD_W-1:0] ROM_PWD     = 8'h3E,
  parameter int               MAX_FAIL    = 3,
  parameter int               LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_bank,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [PWD_W-1:0]  req_pwd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              locked
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  logic              r_reqReady;
  logic              r_rspValid;
  logic [DATA_W-1:0] r_rspRdata;
  logic [1:0]        r_rspErr;
  logic              r_locked;
  logic              r_we;
  logic              r_bank;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [PWD_W-1:0]  r_pwd;
  logic              r_pwdOk;
  logic [DATA_W-1:0] r_ram [DEPTH];
  logic [DATA_W-1:0] r_rom [DEPTH];
  logic [DEPTH-1:0]  r_romWritten;

  logic w_transfer;
  logic w_rspDone;
  logic w_pwdMatch;
  logic w_lockReq;
  logic w_timerDone;

  assign w_transfer = req_valid && r_reqReady;
  assign w_rspDone  = r_rspValid && rsp_ready;
  assign w_pwdMatch = (r_bank == BANK_RAM) ? (r_pwd == RAM_PWD) : (r_pwd == ROM_PWD);

`ifdef SECURE_MEM_LOCKOUT_EN
  logic w_checkEn;
  logic w_lockStart;
  logic w_lockEnd;

  assign w_checkEn   = (r_state == CHECK);
  assign w_lockStart = (r_state == RESP) && w_rspDone && w_lockReq;
  assign w_lockEnd   = (r_state == LOCKOUT) && w_timerDone;

  secure_mem_lockout #(
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout (
    .clk         (clk),
    .rst         (rst),
    .i_checkEn   (w_checkEn),
    .i_pwdOk     (w_pwdMatch),
    .i_lockStart (w_lockStart),
    .i_lockEnd   (w_lockEnd),
    .o_lockReq   (w_lockReq),
    .o_timerDone (w_timerDone)
  );
`else
  assign w_lockReq   = 1'b0;
  assign w_timerDone = 1'b1;
`endif

  // Memory arrays live in the FSM block so a reset mid-request can never leave a partial write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_reqReady   <= 1'b1;
      r_rspValid   <= 1'b0;
      r_rspRdata   <= '0;
      r_rspErr     <= ERR_OK;
      r_locked     <= 1'b0;
      r_we         <= 1'b0;
      r_bank       <= BANK_RAM;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pwd        <= '0;
      r_pwdOk      <= 1'b0;
      r_romWritten <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ram[i] <= '0;
        r_rom[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_transfer) begin
            r_we       <= req_we;
            r_bank     <= req_bank;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_pwd      <= req_pwd;
            r_reqReady <= 1'b0;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          r_pwdOk <= w_pwdMatch;
          r_state <= ACCESS;
        end
        ACCESS: begin
          r_rspValid <= 1'b1;
          r_rspRdata <= '0;
          r_rspErr   <= ERR_OK;
          if (!r_pwdOk) begin
            r_rspErr <= ERR_BAD_PWD;
          end else if (r_bank == BANK_RAM) begin
            if (r_we) begin
              r_ram[r_addr] <= r_wdata;
            end else begin
              r_rspRdata <= r_ram[r_addr];
            end
          end else if (r_we) begin
            if (r_romWritten[r_addr]) begin
              r_rspErr <= ERR_ROM_WP;
            end else begin
              r_rom[r_addr]        <= r_wdata;
              r_romWritten[r_addr] <= 1'b1;
            end
          end else begin
            r_rspRdata <= r_rom[r_addr];
          end
          r_state <= RESP;
        end
        RESP: begin
          if (w_rspDone) begin
            r_rspValid <= 1'b0;
            if (w_lockReq) begin
              r_locked <= 1'b1;
              r_state  <= LOCKOUT;
            end else begin
              r_reqReady <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end
        LOCKOUT: begin
          if (w_timerDone) begin
            r_locked   <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;
  assign locked    = r_locked;

endmodule

// File: tb/tb_secure_mem_ctrl.sv
// Directed scoreboard bench for secure_mem_ctrl; lockout checks follow SECURE_MEM_LOCKOUT_EN.
module tb_secure_mem_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic       req_bank;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] req_pwd;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       locked;

  int totalChecks = 0;
  int badChecks   = 0;

  // Each entry is {expected rdata, expected err}
  logic [9:0] expQ [$];

  secure_mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_bank  (req_bank),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pwd   (req_pwd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveRequest(input logic we, input logic bank, input logic [3:0] addr,
                              input logic [7:0] wdata, input logic [7:0] pwd);
    @(negedge clk);
    compareValue("req_ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_bank  = bank;
    req_addr  = addr;
    req_wdata = wdata;
    req_pwd   = pwd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic bank, input logic [3:0] addr,
                               input logic [7:0] wdata, input logic [7:0] pwd,
                               input logic [7:0] expRdata, input logic [1:0] expErr);
    expQ.push_back({expRdata, expErr});
    driveRequest(we, bank, addr, wdata, pwd);
  endtask

  // Called at the negedge right after the transfer edge; that edge counts as edge 1.
  task automatic checkOutput(input string tag);
    int edges;
    logic [9:0] exp;
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    compareValue({tag, "_latency"}, edges, 32'd3);
    if (expQ.size() == 0) begin
      compareValue({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = expQ.pop_front();
      compareValue({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp[9:2]});
      compareValue({tag, "_err"}, {30'd0, rsp_err}, {30'd0, exp[1:0]});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    compareValue({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int lockCount;
    logic readyLow;
    logic [7:0] heldData;
    logic [1:0] heldErr;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_bank  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_pwd   = '0;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    compareValue("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    compareValue("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    compareValue("reset_rsp_err", {30'd0, rsp_err}, 32'd0);
    compareValue("reset_locked", {31'd0, locked}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    compareValue("reset_req_ready", {31'd0, req_ready}, 32'd1);

    $display("[TB] RAM write then read");
    applyStimulus(1'b1, 1'b0, 4'd3, 8'h5A, 8'hBF, 8'h00, 2'b00);
    checkOutput("ram_wr");
    applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 8'hBF, 8'h5A, 2'b00);
    checkOutput("ram_rd");

    $display("[TB] ROM write-once");
    applyStimulus(1'b1, 1'b1, 4'd1, 8'h11, 8'h3E, 8'h00, 2'b00);
    checkOutput("rom_wr1");
    applyStimulus(1'b1, 1'b1, 4'd1, 8'h22, 8'h3E, 8'h00, 2'b10);
    checkOutput("rom_wr2");
    applyStimulus(1'b0, 1'b1, 4'd1, 8'h00, 8'h3E, 8'h11, 2'b00);
    checkOutput("rom_rd");
    applyStimulus(1'b0, 1'b1, 4'd9, 8'h00, 8'h3E, 8'h00, 2'b00);
    checkOutput("rom_rd_unwritten");

    $display("[TB] bad password");
    applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 8'h00, 8'h00, 2'b01);
    checkOutput("ram_badpwd");
    applyStimulus(1'b1, 1'b0, 4'd3, 8'hEE, 8'hBF ^ 8'h01, 8'h00, 2'b01);
    checkOutput("ram_badpwd_wr");
    applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 8'hBF, 8'h5A, 2'b00);
    checkOutput("ram_unchanged");
    applyStimulus(1'b0, 1'b1, 4'd1, 8'h00, 8'hBF, 8'h00, 2'b01);
    checkOutput("rom_wrong_bank_pwd");
    applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 8'hBF, 8'h5A, 2'b00);
    checkOutput("ram_clear_count");

    $display("[TB] three consecutive bad passwords");
    applyStimulus(1'b0, 1'b0, 4'd2, 8'h00, 8'h01, 8'h00, 2'b01);
    checkOutput("bad1");
    applyStimulus(1'b0, 1'b1, 4'd2, 8'h00, 8'h02, 8'h00, 2'b01);
    checkOutput("bad2");
    applyStimulus(1'b0, 1'b0, 4'd2, 8'h00, 8'h03, 8'h00, 2'b01);
    checkOutput("bad3");
`ifdef SECURE_MEM_LOCKOUT_EN
    lockCount = 0;
    readyLow  = 1'b1;
    while (locked && lockCount < 40) begin
      if (req_ready) readyLow = 1'b0;
      lockCount++;
      @(negedge clk);
    end
    compareValue("lock_cycles", lockCount, 32'd16);
    compareValue("lock_ready_low", {31'd0, readyLow}, 32'd1);
    compareValue("unlock_req_ready", {31'd0, req_ready}, 32'd1);
`else
    lockCount = 0;
    readyLow  = 1'b0;
    compareValue("nolock_locked", {31'd0, locked}, 32'd0);
    compareValue("nolock_req_ready", {31'd0, req_ready}, 32'd1);
`endif
    applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 8'hBF, 8'h5A, 2'b00);
    checkOutput("after_lock");

    $display("[TB] response backpressure");
    applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 8'hBF, 8'h5A, 2'b00);
    while (!rsp_valid && lockCount < 100) begin
      @(negedge clk);
      lockCount++;
    end
    heldData  = rsp_rdata;
    heldErr   = rsp_err;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_bank  = 1'b0;
    req_addr  = 4'd3;
    req_wdata = 8'hFF;
    req_pwd   = 8'hBF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compareValue("stall_valid", {31'd0, rsp_valid}, 32'd1);
      compareValue("stall_rdata", {24'd0, rsp_rdata}, 32'h5A);
      compareValue("stall_err", {30'd0, rsp_err}, {30'd0, heldErr});
      compareValue("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    compareValue("stall_rdata_held", {24'd0, rsp_rdata}, {24'd0, heldData});
    req_valid = 1'b0;
    void'(expQ.pop_front());
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 8'hBF, 8'h5A, 2'b00);
    checkOutput("ignored_write");

    $display("[TB] reset during CHECK of a RAM write");
    driveRequest(1'b1, 1'b0, 4'd5, 8'h77, 8'hBF);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compareValue("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd5, 8'h00, 8'hBF, 8'h00, 2'b00);
    checkOutput("midrst_addr5");
    applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 8'hBF, 8'h00, 2'b00);
    checkOutput("midrst_ram_cleared");
    applyStimulus(1'b0, 1'b1, 4'd1, 8'h00, 8'h3E, 8'h00, 2'b00);
    checkOutput("midrst_rom_cleared");
    applyStimulus(1'b1, 1'b1, 4'd1, 8'h33, 8'h3E, 8'h00, 2'b00);
    checkOutput("midrst_rom_flag_cleared");
    applyStimulus(1'b0, 1'b1, 4'd1, 8'h00, 8'h3E, 8'h33, 2'b00);
    checkOutput("midrst_rom_rd");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/secure_mem_ctrl.md
SECURE_MEM_CTRL -- requirements
Module: secure_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width of both banks.
REQ-002 SHALL have parameter ADDR_W, default 4, word address width; each bank depth 2**ADDR_W.
REQ-003 SHALL have parameter PWD_W, default 8, password width.
REQ-004 SHALL have parameters RAM_PWD, default 8'hBF, and ROM_PWD, default 8'h3E, the per-bank passwords.
REQ-005 SHALL have parameters MAX_FAIL, default 3, and LOCK_CYCLES, default 16, the lockout threshold and duration.
REQ-006 SHALL have port clk  in  1  clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports req_valid in 1 request present; req_ready out 1 request accepted.
REQ-009 SHALL have ports req_we in 1 write(1)/read(0); req_bank in 1 RAM(0)/ROM(1).
REQ-010 SHALL have ports req_addr in ADDR_W; req_wdata in DATA_W; req_pwd in PWD_W.
REQ-011 SHALL have ports rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_W; rsp_err out 2 (00 ok, 01 bad password, 10 ROM write-protected).
REQ-012 SHALL have port locked out 1, high while in lockout.

Function
REQ-013 SHALL use FSM states IDLE, CHECK, ACCESS, RESP, LOCKOUT.
REQ-014 SHALL assert req_ready only in IDLE; transfer occurs on req_valid && req_ready at a rising edge, capturing all req_* fields.
REQ-015 SHALL go IDLE->CHECK on transfer, CHECK->ACCESS always, ACCESS->RESP always; rsp_valid high from the 3rd edge after transfer.
REQ-016 SHALL compare captured req_pwd in CHECK against RAM_PWD (bank 0) or ROM_PWD (bank 1); mismatch gives rsp_err=01, rsp_rdata=0, no write.
REQ-017 SHALL, on RAM match, write req_wdata (we=1) or return the stored word (we=0) with rsp_err=00.
REQ-018 SHALL treat ROM as write-once per address: per-entry written flag; first write stores data and sets flag (err 00); later write leaves data unchanged, err=10.
REQ-019 SHALL return rsp_rdata=0 for writes; ROM read of an unwritten entry returns 0, err 00.
REQ-020 SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready high at an edge, then go RESP->IDLE (or LOCKOUT per REQ-022); no new request accepted meanwhile.
REQ-021 SHALL count consecutive password mismatches (saturating at MAX_FAIL); any password match clears the count.
REQ-022 SHALL, when the count reaches MAX_FAIL, go RESP->LOCKOUT on response handshake, assert locked, hold req_ready=0 for exactly LOCK_CYCLES cycles, then return to IDLE with count cleared.
REQ-023 SHALL compute addresses modulo depth (no out-of-range case).

Reset
REQ-024 SHALL on rst: state IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=00, locked=0, fail count 0, lockout timer 0.
REQ-025 SHALL on rst clear both arrays to 0 and all ROM written flags.
REQ-026 SHALL, if rst asserts mid-request, discard the request; no partial write survives.

Configuration
REQ-027 SHALL, with SECURE_MEM_LOCKOUT_EN defined, implement REQ-021/022; without it, omit fail counter and timer, tie locked=0, never enter LOCKOUT.

Structure
REQ-028 SHALL place state enum, rsp_err code constants and bank-select constants in package secure_mem_pkg.
REQ-029 SHALL implement fail counter plus lockout timer as sub-module secure_mem_lockout, instantiated only under SECURE_MEM_LOCKOUT_EN.

Verification
REQ-030 RAM write addr 3 data 8'h5A pwd BF, then read addr 3 -> rdata 5A, err 00, rsp_valid 3 edges after each transfer.
REQ-031 ROM write addr 1 data 8'h11 pwd 3E, then write 8'h22 -> second err 10; read -> 11.
REQ-032 RAM read with pwd 00 -> err 01, rdata 0; RAM contents unchanged.
REQ-033 Three consecutive bad passwords -> locked=1, req_ready=0 for 16 cycles, then accept; with macro undefined, locked stays 0.
REQ-034 rsp_ready held low 5 cycles -> response stable, req_valid ignored; rst during CHECK of a RAM write -> addr reads 0 afterwards.
